// File: rtl/float_vec_source_if.sv
// float_vec_source_if: valid/ready record stream carrying one float record
// {sign, exponent, significand, LANES packed foo lanes}. The master presents
// records; the slave accepts them with io_ready.
interface float_vec_source_if #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int FOO_W = 16,
  parameter int LANES = 3
);
  logic                     io_valid;
  logic                     io_ready;
  logic                     io_last;
  logic                     io_sign;
  logic [EXP_W-1:0]         io_exponent;
  logic [SIG_W-1:0]         io_significand;
  logic [LANES*FOO_W-1:0]   io_foo;

  modport master (
    output io_valid, io_last, io_sign, io_exponent, io_significand, io_foo,
    input  io_ready
  );

  modport slave (
    input  io_valid, io_last, io_sign, io_exponent, io_significand, io_foo,
    output io_ready
  );
endinterface

// File: rtl/float_vec_source.sv
// float_vec_source: DEPTH-entry loadable float-record store that streams its
// records over a valid/ready port, either once or in repeating passes.
// Records load with the default float constant on reset and may be rewritten
// while idle. Optional feature macro FLOAT_VEC_SRC_STRIDE_EN adds a per-pass
// offset to every foo lane (incremented after each completed looping pass).
module float_vec_source #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int FOO_W = 16,
  parameter int LANES = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic                       wr_sign,
  input  logic [EXP_W-1:0]           wr_exponent,
  input  logic [SIG_W-1:0]           wr_significand,
  input  logic [LANES*FOO_W-1:0]     wr_foo,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       loop,
  input  logic                       stop,
  output logic                       busy,
  float_vec_source_if.master         io
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = LANES * FOO_W;
  localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LEN_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default foo vector: lane i holds 0x16 + 11*i, truncated to the lane width.
  function automatic logic [FW-1:0] default_foo();
    logic [FW-1:0] f;
    logic [31:0]   v;
    f = {FW{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      v = 32'h0000_0016 + (32'd11 * 32'(l));
      f[l*FOO_W +: FOO_W] = FOO_W'(v);
    end
    return f;
  endfunction

  // Record store
  logic            sign_mem_r [DEPTH];
  logic [EXP_W-1:0] exp_mem_r [DEPTH];
  logic [SIG_W-1:0] sig_mem_r [DEPTH];
  logic [FW-1:0]   foo_mem_r  [DEPTH];

  // Control state
  state_t          state_r, state_n;
  logic [AW-1:0]   ptr_r, ptr_n;
  logic [AW:0]     len_r, len_n;
  logic            loop_r, loop_n;
  logic            stop_r, stop_n;

  // Registered outputs
  logic            valid_r, valid_n;
  logic            last_r, last_n;
  logic            sign_r;
  logic [EXP_W-1:0] exponent_r;
  logic [SIG_W-1:0] significand_r;
  logic [FW-1:0]   foo_r;
  logic            busy_r;

  // Datapath helpers
  logic            load_s;
  logic            start_s;
  logic            wrap_s;
  logic [AW-1:0]   rd_idx_s;
  logic [AW:0]     len_eff_s;
  logic            at_last_s;
  logic            fwd_s;
  logic            rd_sign_s;
  logic [EXP_W-1:0] rd_exp_s;
  logic [SIG_W-1:0] rd_sig_s;
  logic [FW-1:0]   rd_foo_s;
  logic [FW-1:0]   load_foo_s;

  assign len_eff_s = (len > LEN_DEPTH) ? LEN_DEPTH : len;
  assign at_last_s = ({1'b0, ptr_r} == (len_r - LEN_ONE));

  // Next-state and next-output logic for the IDLE/RUN streaming FSM.
  always_comb begin
    state_n  = state_r;
    ptr_n    = ptr_r;
    len_n    = len_r;
    loop_n   = loop_r;
    stop_n   = stop_r;
    valid_n  = valid_r;
    last_n   = last_r;
    load_s   = 1'b0;
    start_s  = 1'b0;
    wrap_s   = 1'b0;
    rd_idx_s = ptr_r;
    case (state_r)
      ST_IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        stop_n  = 1'b0;
        if (start && (len != LEN_ZERO)) begin
          state_n  = ST_RUN;
          ptr_n    = PTR_ZERO;
          len_n    = len_eff_s;
          loop_n   = loop;
          valid_n  = 1'b1;
          last_n   = (len_eff_s == LEN_ONE);
          load_s   = 1'b1;
          start_s  = 1'b1;
          rd_idx_s = PTR_ZERO;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        // stop is sticky and also applies to a handshake in its own cycle
        stop_n = stop_r | stop;
        if (valid_r && io.io_ready) begin
          if (at_last_s) begin
            if (loop_r && !(stop_r || stop)) begin
              ptr_n    = PTR_ZERO;
              valid_n  = 1'b1;
              last_n   = (len_r == LEN_ONE);
              load_s   = 1'b1;
              wrap_s   = 1'b1;
              rd_idx_s = PTR_ZERO;
            end else begin
              state_n = ST_IDLE;
              ptr_n   = PTR_ZERO;
              valid_n = 1'b0;
              last_n  = 1'b0;
              stop_n  = 1'b0;
            end
          end else begin
            ptr_n    = ptr_r + PTR_ONE;
            valid_n  = 1'b1;
            last_n   = (({1'b0, ptr_r} + LEN_ONE) == (len_r - LEN_ONE));
            load_s   = 1'b1;
            rd_idx_s = ptr_r + PTR_ONE;
          end
        end else begin
          valid_n = valid_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  // Record read with forwarding of a same-cycle idle write, so a start
  // issued together with a write streams the new data.
  always_comb begin
    fwd_s = (state_r == ST_IDLE) && wr_en && (wr_addr == rd_idx_s);
    if (fwd_s) begin
      rd_sign_s = wr_sign;
      rd_exp_s  = wr_exponent;
      rd_sig_s  = wr_significand;
      rd_foo_s  = wr_foo;
    end else begin
      rd_sign_s = sign_mem_r[rd_idx_s];
      rd_exp_s  = exp_mem_r[rd_idx_s];
      rd_sig_s  = sig_mem_r[rd_idx_s];
      rd_foo_s  = foo_mem_r[rd_idx_s];
    end
  end

`ifdef FLOAT_VEC_SRC_STRIDE_EN
  logic [FOO_W-1:0] offset_r, offset_n;

  // Add the pass offset to every foo lane, each lane wrapping independently.
  function automatic logic [FW-1:0] add_offset(input logic [FW-1:0] foo,
                                               input logic [FOO_W-1:0] off);
    logic [FW-1:0] r;
    r = {FW{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      r[l*FOO_W +: FOO_W] = foo[l*FOO_W +: FOO_W] + off;
    end
    return r;
  endfunction

  // Offset for the record being loaded: cleared on start, bumped on loop-back.
  always_comb begin
    if (start_s) begin
      offset_n = {FOO_W{1'b0}};
    end else if (wrap_s) begin
      offset_n = offset_r + FOO_W'(1);
    end else begin
      offset_n = offset_r;
    end
  end

  // Pass offset register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      offset_r <= {FOO_W{1'b0}};
    end else begin
      offset_r <= offset_n;
    end
  end

  assign load_foo_s = add_offset(rd_foo_s, offset_n);
`else
  assign load_foo_s = rd_foo_s;
`endif

  // FSM state, pointer, and latched stream parameters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_ZERO;
      len_r   <= LEN_ZERO;
      loop_r  <= 1'b0;
      stop_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      len_r   <= len_n;
      loop_r  <= loop_n;
      stop_r  <= stop_n;
    end
  end

  // Output registers; record fields change only when a new record loads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_r       <= 1'b0;
      last_r        <= 1'b0;
      sign_r        <= 1'b0;
      exponent_r    <= {EXP_W{1'b0}};
      significand_r <= {SIG_W{1'b0}};
      foo_r         <= {FW{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      valid_r <= valid_n;
      last_r  <= last_n;
      busy_r  <= (state_n == ST_RUN);
      if (load_s) begin
        sign_r        <= rd_sign_s;
        exponent_r    <= rd_exp_s;
        significand_r <= rd_sig_s;
        foo_r         <= load_foo_s;
      end
    end
  end

  // Record store: defaults on reset, writes accepted only while idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        sign_mem_r[d] <= 1'b1;
        exp_mem_r[d]  <= EXP_W'(8'h0A);
        sig_mem_r[d]  <= SIG_W'(8'h80);
        foo_mem_r[d]  <= default_foo();
      end
    end else if ((state_r == ST_IDLE) && wr_en) begin
      sign_mem_r[wr_addr] <= wr_sign;
      exp_mem_r[wr_addr]  <= wr_exponent;
      sig_mem_r[wr_addr]  <= wr_significand;
      foo_mem_r[wr_addr]  <= wr_foo;
    end
  end

  assign io.io_valid       = valid_r;
  assign io.io_last        = last_r;
  assign io.io_sign        = sign_r;
  assign io.io_exponent    = exponent_r;
  assign io.io_significand = significand_r;
  assign io.io_foo         = foo_r;
  assign busy              = busy_r;

endmodule

// File: tb/tb_float_vec_source.sv
// Testbench for float_vec_source: randomized streams checked against a
// record-list model (records, passes, per-pass lane offset when
// FLOAT_VEC_SRC_STRIDE_EN is defined).
module tb_float_vec_source;
  localparam int EXP_W = 8;
  localparam int SIG_W = 23;
  localparam int FOO_W = 16;
  localparam int LANES = 3;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FW    = LANES * FOO_W;
`ifdef FLOAT_VEC_SRC_STRIDE_EN
  localparam bit STRIDE = 1'b1;
`else
  localparam bit STRIDE = 1'b0;
`endif

  typedef struct packed {
    logic             last;
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [SIG_W-1:0] sig;
    logic [FW-1:0]    foo;
  } rec_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             wr_sign;
  logic [EXP_W-1:0] wr_exponent;
  logic [SIG_W-1:0] wr_significand;
  logic [FW-1:0]    wr_foo;
  logic             start;
  logic [AW:0]      len;
  logic             loop;
  logic             stop;
  logic             busy;

  float_vec_source_if #(.EXP_W(EXP_W), .SIG_W(SIG_W), .FOO_W(FOO_W), .LANES(LANES)) io_if ();

  float_vec_source #(.EXP_W(EXP_W), .SIG_W(SIG_W), .FOO_W(FOO_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sign(wr_sign), .wr_exponent(wr_exponent), .wr_significand(wr_significand),
    .wr_foo(wr_foo), .start(start), .len(len), .loop(loop), .stop(stop),
    .busy(busy), .io(io_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model of the record store
  logic             m_sign [DEPTH];
  logic [EXP_W-1:0] m_exp  [DEPTH];
  logic [SIG_W-1:0] m_sig  [DEPTH];
  logic [FW-1:0]    m_foo  [DEPTH];

  // Observations of the last collected stream
  rec_t obs_q[$];
  int   hs_count;
  int   valid_cycles;
  int   stall_err;
  bit   timed_out;

  function automatic void model_reset();
    for (int d = 0; d < DEPTH; d++) begin
      m_sign[d] = 1'b1;
      m_exp[d]  = 8'h0A;
      m_sig[d]  = 23'h80;
      for (int l = 0; l < LANES; l++) m_foo[d][l*FOO_W +: FOO_W] = 16'(22 + 11 * l);
    end
  endfunction

  // k-th handshake of a stream of passes of L records
  function automatic rec_t exp_rec(int k, int L);
    rec_t r;
    int idx;
    int pass;
    idx  = k % L;
    pass = k / L;
    r.last = (idx == L - 1);
    r.sign = m_sign[idx];
    r.expo = m_exp[idx];
    r.sig  = m_sig[idx];
    for (int l = 0; l < LANES; l++)
      r.foo[l*FOO_W +: FOO_W] = m_foo[idx][l*FOO_W +: FOO_W] + (STRIDE ? 16'(pass) : 16'h0000);
    return r;
  endfunction

  function automatic int exp_count(int L, bit lp, int stop_hs);
    if (!lp) return L;
    return (stop_hs / L + 1) * L;
  endfunction

  function automatic int clamp_len(int L);
    return (L > DEPTH) ? DEPTH : L;
  endfunction

  task automatic pulse_start(int L, bit lp);
    start = 1'b1; len = 3'(L); loop = lp;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic write_rec(int a, bit s, logic [EXP_W-1:0] e, logic [SIG_W-1:0] sg, logic [FW-1:0] f);
    wr_en = 1'b1; wr_addr = AW'(a); wr_sign = s; wr_exponent = e; wr_significand = sg; wr_foo = f;
    @(negedge clock);
    wr_en = 1'b0;
    m_sign[a] = s; m_exp[a] = e; m_sig[a] = sg; m_foo[a] = f;
  endtask

  // Drive io_ready (0: always, 1: toggle, 2: random) and record handshakes until
  // io_valid drops, max_hs handshakes occur, or the cycle budget runs out.
  task automatic collect(int mode, int stop_hs, int max_hs, bit wr_in_run);
    rec_t cur;
    rec_t prev;
    bit   prev_stall;
    obs_q.delete();
    hs_count = 0; valid_cycles = 0; stall_err = 0; timed_out = 1'b1;
    prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      wr_en = 1'b0; stop = 1'b0;
      case (mode)
        0:       io_if.io_ready = 1'b1;
        1:       io_if.io_ready = (cyc % 2 == 0);
        default: io_if.io_ready = 1'($urandom_range(0, 1));
      endcase
      cur = {io_if.io_last, io_if.io_sign, io_if.io_exponent, io_if.io_significand, io_if.io_foo};
      if (prev_stall && (!io_if.io_valid || cur !== prev)) stall_err++;
      if (!io_if.io_valid) begin timed_out = 1'b0; break; end
      valid_cycles++;
      if (wr_in_run) begin
        wr_en = 1'b1; wr_addr = AW'($urandom); wr_sign = 1'($urandom);
        wr_exponent = EXP_W'($urandom); wr_significand = SIG_W'($urandom);
        wr_foo = {16'($urandom), 16'($urandom), 16'($urandom)};
      end
      if (io_if.io_ready) begin
        if (hs_count == stop_hs) stop = 1'b1;
        obs_q.push_back(cur);
        hs_count++;
      end
      prev_stall = !io_if.io_ready;
      prev = cur;
      @(negedge clock);
      if (max_hs > 0 && hs_count >= max_hs) begin timed_out = 1'b0; break; end
    end
    wr_en = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rec_t cur;
    cur = {io_if.io_last, io_if.io_sign, io_if.io_exponent, io_if.io_significand, io_if.io_foo};
    n_checks++;
    if (io_if.io_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", io_if.io_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (cur !== '0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", cur); end
  endtask

  task automatic test_single();
    rec_t lit;
    lit = {1'b1, 1'b1, 8'h0A, 23'h000080, 48'h002C_0021_0016};
    pulse_start(1, 1'b0);
    collect(0, -1, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d (timeout %0b) want 1", obs_q.size(), timed_out);
    end else begin
      n_checks++;
      if (obs_q[0] !== exp_rec(0, 1)) begin n_fail++; $display("FAIL single_rec: got %h want %h", obs_q[0], exp_rec(0, 1)); end
      n_checks++;
      if (obs_q[0] !== lit) begin n_fail++; $display("FAIL single_default: got %h want %h", obs_q[0], lit); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_write_stall();
    write_rec(2, 1'b0, 8'h7F, 23'h400000, {16'd3, 16'd2, 16'd1});
    pulse_start(3, 1'b0);
    collect(1, -1, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 3) begin
      n_fail++; $display("FAIL stall_count: got %0d want 3", obs_q.size());
    end
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_rec(k, 3)) begin n_fail++; $display("FAIL stall_rec[%0d]: got %h want %h", k, obs_q[k], exp_rec(k, 3)); end
    end
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes want 0", stall_err); end
  endtask

  task automatic test_back_to_back();
    pulse_start(2, 1'b1);
    collect(0, 2, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 4) begin n_fail++; $display("FAIL loop_count: got %0d want 4", obs_q.size()); end
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_rec(k, 2)) begin n_fail++; $display("FAIL loop_rec[%0d]: got %h want %h", k, obs_q[k], exp_rec(k, 2)); end
    end
    n_checks++;
    if (valid_cycles != 4) begin n_fail++; $display("FAIL loop_bubble: got %0d valid cycles want 4", valid_cycles); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_busy_end: got %b want 0", busy); end
    // restart in the very next cycle; stop coincides with the last handshake
    pulse_start(2, 1'b1);
    n_checks++;
    if (io_if.io_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b want 1", io_if.io_valid); end
    collect(0, 1, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 2) begin n_fail++; $display("FAIL stop_on_last_count: got %0d want 2", obs_q.size()); end
  endtask

  task automatic test_len_edges();
    pulse_start(0, 1'b0);
    collect(0, -1, 0, 1'b0);
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0: got %0d records busy %b want 0 records busy 0", obs_q.size(), busy);
    end
    pulse_start(7, 1'b0);
    collect(2, -1, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != clamp_len(7)) begin n_fail++; $display("FAIL len7_count: got %0d want %0d", obs_q.size(), clamp_len(7)); end
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_rec(k, clamp_len(7))) begin n_fail++; $display("FAIL len7_rec[%0d]: got %h want %h", k, obs_q[k], exp_rec(k, 4)); end
    end
  endtask

  task automatic test_write_during_run();
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start(4, 1'b0);
      collect(2, -1, 0, (pass == 0));
      n_checks++;
      if (timed_out || obs_q.size() != 4) begin n_fail++; $display("FAIL wrrun_count[%0d]: got %0d want 4", pass, obs_q.size()); end
      foreach (obs_q[k]) begin
        n_checks++;
        if (obs_q[k] !== exp_rec(k, 4)) begin n_fail++; $display("FAIL wrrun_rec[%0d.%0d]: got %h want %h", pass, k, obs_q[k], exp_rec(k, 4)); end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int L;
      int Lm;
      bit lp;
      int stop_hs;
      int a;
      L  = $urandom_range(1, 7);
      Lm = clamp_len(L);
      lp = 1'($urandom_range(0, 1));
      stop_hs = lp ? $urandom_range(0, 2 * Lm) : -1;
      write_rec($urandom_range(0, DEPTH - 1), 1'($urandom), EXP_W'($urandom), SIG_W'($urandom),
                {16'($urandom), 16'($urandom), 16'($urandom)});
      // write and start in the same idle cycle
      a = $urandom_range(0, DEPTH - 1);
      wr_en = 1'b1; wr_addr = AW'(a); wr_sign = 1'($urandom); wr_exponent = EXP_W'($urandom);
      wr_significand = SIG_W'($urandom); wr_foo = {16'($urandom), 16'($urandom), 16'($urandom)};
      m_sign[a] = wr_sign; m_exp[a] = wr_exponent; m_sig[a] = wr_significand; m_foo[a] = wr_foo;
      pulse_start(L, lp);
      wr_en = 1'b0;
      collect(2, stop_hs, 0, 1'b0);
      n_checks++;
      if (timed_out || obs_q.size() != exp_count(Lm, lp, stop_hs)) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, obs_q.size(), exp_count(Lm, lp, stop_hs));
      end
      foreach (obs_q[k]) begin
        n_checks++;
        if (obs_q[k] !== exp_rec(k, Lm)) begin n_fail++; $display("FAIL rand_rec[%0d.%0d]: got %h want %h", it, k, obs_q[k], exp_rec(k, Lm)); end
      end
      n_checks++;
      if (stall_err != 0) begin n_fail++; $display("FAIL rand_hold[%0d]: got %0d changes want 0", it, stall_err); end
    end
  endtask

  task automatic test_reset_mid();
    write_rec(0, 1'b0, 8'h55, 23'h012345, 48'h1111_2222_3333);
    pulse_start(4, 1'b1);
    collect(0, -1, 2, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 2) begin n_fail++; $display("FAIL rmid_pre: got %0d want 2", obs_q.size()); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (io_if.io_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort: got valid %b busy %b want 0 0", io_if.io_valid, busy);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    pulse_start(4, 1'b0);
    collect(0, -1, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 4) begin n_fail++; $display("FAIL rmid_count: got %0d want 4", obs_q.size()); end
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_rec(k, 4)) begin n_fail++; $display("FAIL rmid_rec[%0d]: got %h want %h", k, obs_q[k], exp_rec(k, 4)); end
    end
  endtask

  task automatic test_stride();
    logic [FOO_W-1:0] want;
    pulse_start(1, 1'b1);
    collect(0, 3, 0, 1'b0);
    n_checks++;
    if (timed_out || obs_q.size() != 4) begin n_fail++; $display("FAIL stride_count: got %0d want 4", obs_q.size()); end
    foreach (obs_q[k]) begin
      want = STRIDE ? 16'(22 + k) : 16'h0016;
      n_checks++;
      if (obs_q[k].foo[FOO_W-1:0] !== want) begin
        n_fail++; $display("FAIL stride_lane0[%0d]: got %h want %h", k, obs_q[k].foo[FOO_W-1:0], want);
      end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_sign = 1'b0; wr_exponent = '0;
    wr_significand = '0; wr_foo = '0; start = 1'b0; len = '0; loop = 1'b0; stop = 1'b0;
    io_if.io_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_single();
    test_write_stall();
    test_back_to_back();
    test_len_edges();
    test_write_during_run();
    test_random();
    test_reset_mid();
    test_stride();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_vec_source.md
# float_vec_source

Parametrised, loadable successor to the constant float-record bundle. Holds DEPTH records; each record is {sign, exponent, significand, LANES-wide foo vector}. Records reset to the team's default float constant. On command, the block streams records over a valid/ready port, either as one pass or looping. It sits between configuration logic and any consumer of float-record test or coefficient streams.

## Interface
- EXP_W, 8, exponent width
- SIG_W, 23, significand width
- FOO_W, 16, width of each foo lane
- LANES, 3, number of foo lanes (>=1)
- DEPTH, 4, record count; power of two, >=2; AW = log2(DEPTH)
- clock  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  write record wr_addr (honoured only in IDLE)
- wr_addr  in  AW  record index
- wr_sign / wr_exponent / wr_significand  in  1 / EXP_W / SIG_W  write data
- wr_foo  in  LANES*FOO_W  lane i at [i*FOO_W +: FOO_W]
- start  in  1  begin streaming (honoured only in IDLE)
- len  in  AW+1  records per pass; sampled with start
- loop  in  1  repeat passes; sampled with start
- stop  in  1  request end of looping after the current pass
- io_ready  in  1  consumer accepts
- io_valid  out  1  record presented
- io_last  out  1  presented record is last of its pass
- io_sign / io_exponent / io_significand  out  1 / EXP_W / SIG_W  record fields
- io_foo  out  LANES*FOO_W  record lanes, same packing as wr_foo
- busy  out  1  high in RUN

## Operation
- Reset (reset==0 at an edge): every record becomes sign=1, exponent=0xA, significand=0x80, foo lane i = 0x16 + 11*i, truncated to FOO_W. Lanes 0..2 are 0x16, 0x21, 0x2C.
- All io_* outputs and busy reset to 0. FSM resets to IDLE. Pointer, stop flag and offset reset to 0.
- FSM states: IDLE, RUN.
- IDLE + start:
  - len==0: start is ignored.
  - len>DEPTH: clamped to DEPTH.
  - Otherwise latch len and loop, clear ptr and the stop flag, go to RUN.
- RUN:
  - io_valid=1 and record[ptr] is presented.
  - io_last = (ptr == len-1).
  - A handshake (io_valid && io_ready) advances ptr.
  - Handshake on the last record:
    - If loop is set and the stop flag is clear: ptr returns to 0.
    - Otherwise: go to IDLE and drop io_valid.
- stop: sets a sticky flag in RUN. It is ignored in IDLE.
  - stop in the same cycle as a last handshake applies to that handshake.
  - Effect: the current pass completes, then the block returns to IDLE.
- Writes:
  - Accepted only in IDLE, effective next cycle.
  - Dropped in RUN.
  - start and wr_en in the same IDLE cycle: the write lands first, so the stream sees the new data.
- While io_valid=1 and io_ready=0, all io_* outputs hold stable.
- Reset mid-stream: aborts immediately. The next cycle shows io_valid=0, and records revert to defaults.

## Timing
- Outputs are registered. start sampled at edge t gives io_valid=1 after edge t, with record 0.
- One record per cycle under continuous io_ready. No bubble between passes in loop mode.
- After the final handshake at edge t, io_valid=0 and busy=0 after edge t. A new start is accepted at edge t+1.
- io_valid never drops without a handshake, except on reset.

## Configuration
- FLOAT_VEC_SRC_STRIDE_EN defined:
  - A FOO_W-bit pass offset is cleared on start and incremented on each completed looping pass, wrapping mod 2^FOO_W.
  - Each output lane = stored lane + offset (mod 2^FOO_W).
  - sign, exponent and significand are unaffected.
- Undefined: no offset logic; io_foo equals the stored lanes.

## Test plan
- Reset, then start with len=1, loop=0, io_ready=1 -> one cycle of io_valid with io_last=1, sign=1, exponent=0x0A, significand=0x000080, foo=0x2C,0x21,0x16 (lanes 2..0); then IDLE.
- Write record 2 = {0, 0x7F, 0x400000, lanes 1,2,3}, then start len=3 with io_ready toggling 1,0,1,... -> records 0,1,2 in order; outputs held during stalls; io_last only on record 2.
- start len=2, loop=1, stop pulsed during the second pass -> exactly 4 handshakes (0,1,0,1), then busy=0.
- start with len=0 -> no io_valid. start with len=7 (DEPTH=4) -> 4 records emitted.
- wr_en during RUN -> data unchanged on the next pass. Reset asserted mid-stream -> io_valid=0 next cycle and records back to defaults.
- With FLOAT_VEC_SRC_STRIDE_EN, start len=1, loop=1, io_ready=1 -> lane 0 emits 0x16, 0x17, 0x18, ...; without the macro it stays 0x16.
